exe_hazard_ctrl: RTL and testbench
==================================

Name: exe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the execute stage of the 5-stage core.
- Tracks destination and control bits of in-flight instructions in EXE, MEM and WB via internal shadow registers.
- Drives operand-forwarding selects for the EXE-stage operand muxes (data1 path and reg2 path).
- Generates load-use stalls, branch flushes and a memory-wait freeze, with a watchdog on the memory handshake.

Parameters:
- FWD_EN, 1, 1 = forwarding enabled; 0 = forwarding disabled, stall on any RAW against EXE or MEM.
- MEM_TIMEOUT, 255, maximum consecutive mem_busy cycles before mem_err asserts (8-bit counter, range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- id_valid  in  1  ID stage holds a real instruction.
- id_src1  in  5  ID source register 1.
- id_src2  in  5  ID source register 2.
- id_two_src  in  1  id_src2 is actually read (R-type, store, branch).
- id_dest  in  5  ID destination register.
- id_wb_en  in  1  ID instruction writes back.
- id_mem_read  in  1  ID instruction is a load.
- br_select  in  1  branch taken, from the EXE condition check.
- mem_busy  in  1  data memory not ready; MEM stage must hold.
- fwd_sel1  out  2  EXE data1 source: 00 register file, 01 MEM-stage ALU result, 10 WB value.
- fwd_sel2  out  2  EXE reg2/data2 source, same encoding.
- stall_if_id  out  1  hold PC and IF/ID register.
- bubble_id_exe  out  1  ID/EXE register loads a bubble (all control bits 0).
- flush_if_id  out  1  IF/ID register loads a bubble.
- freeze  out  1  hold all pipeline registers.
- mem_err  out  1  sticky watchdog error.
- state  out  2  00 RUN, 01 MEM_WAIT, 10 ERR.

Behaviour:
- Shadow registers: exe_{src1,src2,two_src,dest,wb_en,mem_read}, mem_{dest,wb_en}, wb_{dest,wb_en}.
- When freeze=0, each clock: WB←MEM, MEM←EXE, EXE←ID inputs. EXE loads a bubble (wb_en=0, mem_read=0, dest=0, two_src=0) when bubble_id_exe=1 or id_valid=0.
- When freeze=1: all shadow registers hold.
- Register 0 never matches: no forwarding and no hazard on R0.
- Forwarding (combinational, FWD_EN=1), for each EXE source s:
  - 01 if mem_wb_en and mem_dest==s.
  - else 10 if wb_wb_en and wb_dest==s.
  - else 00.
  - MEM has priority over WB.
  - fwd_sel2 is forced to 00 when exe_two_src=0.
- Forwarding with FWD_EN=0: both fwd_sel outputs are constant 00.
- Load-use (FWD_EN=1) asserts when all hold:
  - id_valid and exe_mem_read and exe_wb_en and exe_dest≠0;
  - id_src1==exe_dest, or (id_two_src and id_src2==exe_dest).
- RAW (FWD_EN=0): same match rule applied to an EXE or MEM destination with wb_en set.
- Hazard response: stall_if_id=1 and bubble_id_exe=1 for exactly the hazard cycles. Load-use costs exactly one cycle.
- Branch: br_select=1 in RUN gives flush_if_id=1 and bubble_id_exe=1 in the same cycle; stall_if_id=0 so the PC loads the branch target.
- Priority: freeze > branch flush > hazard stall. When flush is active, stall_if_id is forced to 0.
- FSM:
  - RUN: mem_busy=1 → MEM_WAIT; freeze is combinationally 1 in that same cycle.
  - MEM_WAIT: freeze=1 while mem_busy=1; the 8-bit counter increments.
  - MEM_WAIT, mem_busy=0: freeze=0 that cycle, → RUN, counter cleared.
  - MEM_WAIT, counter reaches MEM_TIMEOUT: → ERR, mem_err=1.
  - ERR: freeze=1 permanently; only reset exits.
- While freeze=1, br_select and hazards are ignored: flush, stall and bubble outputs are 0, and the pipeline holds.
- Reset (rst=0, any time including mid-MEM_WAIT):
  - shadow registers are set to bubbles; state RUN; counter 0; mem_err 0;
  - outputs: fwd_sel 00, stall 0, bubble 0, flush 0, freeze 0.
- Latency: all control outputs are combinational from the current state and inputs. Shadow state updates on the rising edge.

Decomposition:
- Shared pipeline package holds:
  - the forwarding-select encodings (FWD_RF, FWD_MEM, FWD_WB);
  - the state encodings;
  - the bubble constant for the control bundle;
  - the register-index width (5).
- One sub-module: exe_fwd_sel, a pure comparator producing one 2-bit select. It is instantiated twice.

Test Plan:
- add r3 in EXE, then sub r4,r3,r5 → next cycle fwd_sel1=01; one cycle later for a user of r3, fwd_sel=10. stall_if_id stays 0.
- lw r2 in EXE, ID add r6,r2,r2 → stall_if_id=1 and bubble_id_exe=1 for 1 cycle. Next cycle stall=0, and the add sees fwd_sel1=fwd_sel2=10.
- br_select=1 together with a load-use hazard → flush_if_id=1, bubble_id_exe=1, stall_if_id=0.
- mem_busy high for 3 cycles → freeze=1 for 3 cycles, state=01, shadow registers unchanged, then RUN and normal shifting.
- MEM_TIMEOUT=4 and mem_busy held high → state=10 and mem_err=1 after 4 MEM_WAIT cycles. rst=0 clears all outputs immediately (asynchronous).
- FWD_EN=0, add r3 followed by a user of r3 → stall for 2 cycles (EXE then MEM match), fwd_sel stays 00. Writes to r0 never stall or forward.

Source files
------------

// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared execute-stage pipeline definitions: register index width, forwarding
// select and FSM encodings, shadow control bundles and their bubble values.
package exe_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_t;

  typedef struct packed {
    reg_idx_t src1;
    reg_idx_t src2;
    logic     two_src;
    reg_idx_t dest;
    logic     wb_en;
    logic     mem_read;
  } exe_ctrl_t;

  typedef struct packed {
    reg_idx_t dest;
    logic     wb_en;
  } wb_ctrl_t;

  localparam exe_ctrl_t EXE_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  // R0 is hardwired zero, so a write to it never produces a dependency.
  function automatic logic dest_hit(reg_idx_t dest, logic wb_en, reg_idx_t src);
    return wb_en && (dest != '0) && (dest == src);
  endfunction

endpackage

// File: rtl/exe_fwd_sel.sv
// Forwarding select for one EXE operand: MEM result beats WB value beats RF.
// Purely combinational; no state and no flow control.
module exe_fwd_sel
  import exe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             src_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (src_en) begin
      if (dest_hit(mem_dest, mem_wb_en, src)) begin
        sel = FWD_MEM;
      end else if (dest_hit(wb_dest, wb_wb_en, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage sequencing: forwarding selects, load-use/RAW stalls, branch flush, memory-wait freeze.
// Outputs are combinational from shadow state and inputs; freeze holds every pipeline register.
module exe_hazard_ctrl
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic       id_two_src,
  input  logic [4:0] id_dest,
  input  logic       id_wb_en,
  input  logic       id_mem_read,
  input  logic       br_select,
  input  logic       mem_busy,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2,
  output logic       stall_if_id,
  output logic       bubble_id_exe,
  output logic       flush_if_id,
  output logic       freeze,
  output logic       mem_err,
  output logic [1:0] state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  exe_ctrl_t  exe_q;
  wb_ctrl_t   mem_q;
  wb_ctrl_t   wb_q;
  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       mem_err_q;
  logic       mem_err_d;
  logic       freeze_c;
  logic       active;
  logic       exe_raw;
  logic       mem_raw;
  logic       hazard;
  logic [1:0] sel1_raw;
  logic [1:0] sel2_raw;

  exe_fwd_sel u_fwd1 (
    .src       (exe_q.src1),
    .src_en    (1'b1),
    .mem_dest  (mem_q.dest),
    .mem_wb_en (mem_q.wb_en),
    .wb_dest   (wb_q.dest),
    .wb_wb_en  (wb_q.wb_en),
    .sel       (sel1_raw)
  );

  exe_fwd_sel u_fwd2 (
    .src       (exe_q.src2),
    .src_en    (exe_q.two_src),
    .mem_dest  (mem_q.dest),
    .mem_wb_en (mem_q.wb_en),
    .wb_dest   (wb_q.dest),
    .wb_wb_en  (wb_q.wb_en),
    .sel       (sel2_raw)
  );

  assign fwd_sel1 = (FWD_EN != 0) ? sel1_raw : FWD_RF;
  assign fwd_sel2 = (FWD_EN != 0) ? sel2_raw : FWD_RF;

  // ID reads a register that an older in-flight instruction will write.
  assign exe_raw = id_valid && exe_q.wb_en && (exe_q.dest != '0) &&
                   ((id_src1 == exe_q.dest) || (id_two_src && (id_src2 == exe_q.dest)));
  assign mem_raw = id_valid && mem_q.wb_en && (mem_q.dest != '0) &&
                   ((id_src1 == mem_q.dest) || (id_two_src && (id_src2 == mem_q.dest)));
  assign hazard  = (FWD_EN != 0) ? (exe_raw && exe_q.mem_read) : (exe_raw || mem_raw);

  // Freeze dominates; a taken branch squashes the stalled instruction anyway.
  assign active        = rst && !freeze_c;
  assign freeze        = rst && freeze_c;
  assign flush_if_id   = active && br_select;
  assign stall_if_id   = active && !br_select && hazard;
  assign bubble_id_exe = active && (br_select || hazard);
  assign mem_err       = mem_err_q;
  assign state         = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    freeze_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          freeze_c = 1'b1;
          state_d  = ST_MEM_WAIT;
          cnt_d    = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          freeze_c = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_ERR: begin
        freeze_c = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q <= EXE_BUBBLE;
      mem_q <= WB_BUBBLE;
      wb_q  <= WB_BUBBLE;
    end else if (!freeze_c) begin
      wb_q  <= mem_q;
      mem_q <= '{dest: exe_q.dest, wb_en: exe_q.wb_en};
      if (bubble_id_exe || !id_valid) begin
        exe_q <= EXE_BUBBLE;
      end else begin
        exe_q <= '{src1: id_src1, src2: id_src2, two_src: id_two_src,
                   dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};
      end
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl: default, short-timeout and no-forwarding builds share stimulus.
module tb_exe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_two_src;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_read;
  logic       br_select;
  logic       mem_busy;

  logic [1:0] fwd_sel1, fwd_sel2, state;
  logic       stall_if_id, bubble_id_exe, flush_if_id, freeze, mem_err;
  logic [1:0] to_fwd_sel1, to_fwd_sel2, to_state;
  logic       to_stall, to_bubble, to_flush, to_freeze, to_mem_err;
  logic [1:0] nf_fwd_sel1, nf_fwd_sel2, nf_state;
  logic       nf_stall, nf_bubble, nf_flush, nf_freeze, nf_mem_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exe_hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .br_select(br_select), .mem_busy(mem_busy), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_if_id(stall_if_id), .bubble_id_exe(bubble_id_exe), .flush_if_id(flush_if_id),
    .freeze(freeze), .mem_err(mem_err), .state(state)
  );

  exe_hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .br_select(br_select), .mem_busy(mem_busy), .fwd_sel1(to_fwd_sel1), .fwd_sel2(to_fwd_sel2),
    .stall_if_id(to_stall), .bubble_id_exe(to_bubble), .flush_if_id(to_flush),
    .freeze(to_freeze), .mem_err(to_mem_err), .state(to_state)
  );

  exe_hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(255)) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .br_select(br_select), .mem_busy(mem_busy), .fwd_sel1(nf_fwd_sel1), .fwd_sel2(nf_fwd_sel2),
    .stall_if_id(nf_stall), .bubble_id_exe(nf_bubble), .flush_if_id(nf_flush),
    .freeze(nf_freeze), .mem_err(nf_mem_err), .state(nf_state)
  );

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic two,
                        input logic [4:0] d, input logic wb, input logic mr);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dest = d; id_wb_en = wb; id_mem_read = mr;
  endtask

  task automatic clear_id();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_id();
    br_select = 1'b0;
    mem_busy  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    br_select = 1'b1;
    mem_busy  = 1'b1;
    #3;
    total++; if (fwd_sel1 !== 2'b00) begin bad++; $display("FAIL rst_fwd1 got=%0d want=0", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'b00) begin bad++; $display("FAIL rst_fwd2 got=%0d want=0", fwd_sel2); end
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", stall_if_id); end
    total++; if (bubble_id_exe !== 1'b0) begin bad++; $display("FAIL rst_bubble got=%0b want=0", bubble_id_exe); end
    total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0b want=0", flush_if_id); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL rst_freeze got=%0b want=0", freeze); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL rst_mem_err got=%0b want=0", mem_err); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    @(posedge clk);
    #2;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL rst_state_clk got=%0d want=0", state); end
    total++; if (to_freeze !== 1'b0) begin bad++; $display("FAIL rst_to_freeze got=%0b want=0", to_freeze); end
    do_reset();
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    settle();
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL fwd_a_stall got=%0b want=0", stall_if_id); end
    tick();
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL fwd_b_stall got=%0b want=0", stall_if_id); end
    total++; if (fwd_sel1 !== 2'b00) begin bad++; $display("FAIL fwd_b_sel1 got=%0d want=0", fwd_sel1); end
    tick();
    set_id(1'b1, 5'd5, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);
    settle();
    total++; if (fwd_sel1 !== 2'b01) begin bad++; $display("FAIL fwd_c_sel1 got=%0d want=1", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'b00) begin bad++; $display("FAIL fwd_c_sel2 got=%0d want=0", fwd_sel2); end
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL fwd_c_stall got=%0b want=0", stall_if_id); end
    tick();
    clear_id();
    settle();
    total++; if (fwd_sel1 !== 2'b00) begin bad++; $display("FAIL fwd_d_sel1 got=%0d want=0", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'b10) begin bad++; $display("FAIL fwd_d_sel2 got=%0d want=2", fwd_sel2); end
  endtask

  task automatic test_priority();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
    settle();
    total++; if (fwd_sel1 !== 2'b01) begin bad++; $display("FAIL pri_c_sel1 got=%0d want=1", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'b00) begin bad++; $display("FAIL pri_one_src_sel2 got=%0d want=0", fwd_sel2); end
    tick();
    clear_id();
    settle();
    total++; if (fwd_sel1 !== 2'b01) begin bad++; $display("FAIL pri_mem_sel1 got=%0d want=1", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'b01) begin bad++; $display("FAIL pri_mem_sel2 got=%0d want=1", fwd_sel2); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    total++; if (stall_if_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", stall_if_id); end
    total++; if (bubble_id_exe !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%0b want=1", bubble_id_exe); end
    total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL lu_flush got=%0b want=0", flush_if_id); end
    tick();
    settle();
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL lu_next_stall got=%0b want=0", stall_if_id); end
    total++; if (bubble_id_exe !== 1'b0) begin bad++; $display("FAIL lu_next_bubble got=%0b want=0", bubble_id_exe); end
    tick();
    clear_id();
    settle();
    total++; if (fwd_sel1 !== 2'b10) begin bad++; $display("FAIL lu_wb_sel1 got=%0d want=2", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'b10) begin bad++; $display("FAIL lu_wb_sel2 got=%0d want=2", fwd_sel2); end
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    br_select = 1'b1;
    settle();
    total++; if (flush_if_id !== 1'b1) begin bad++; $display("FAIL br_flush got=%0b want=1", flush_if_id); end
    total++; if (bubble_id_exe !== 1'b1) begin bad++; $display("FAIL br_bubble got=%0b want=1", bubble_id_exe); end
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL br_stall got=%0b want=0", stall_if_id); end
    tick();
    br_select = 1'b0;
    clear_id();
    settle();
    total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL br_after_flush got=%0b want=0", flush_if_id); end
  endtask

  task automatic test_freeze();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd4, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
    mem_busy  = 1'b1;
    br_select = 1'b1;
    settle();
    total++; if (freeze !== 1'b1) begin bad++; $display("FAIL frz_c_freeze got=%0b want=1", freeze); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL frz_c_state got=%0d want=0", state); end
    total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL frz_c_flush got=%0b want=0", flush_if_id); end
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL frz_c_stall got=%0b want=0", stall_if_id); end
    total++; if (bubble_id_exe !== 1'b0) begin bad++; $display("FAIL frz_c_bubble got=%0b want=0", bubble_id_exe); end
    total++; if (fwd_sel1 !== 2'b01) begin bad++; $display("FAIL frz_c_sel1 got=%0d want=1", fwd_sel1); end
    for (int i = 0; i < 2; i++) begin
      tick();
      settle();
      total++; if (freeze !== 1'b1) begin bad++; $display("FAIL frz_wait_freeze[%0d] got=%0b want=1", i, freeze); end
      total++; if (state !== 2'b01) begin bad++; $display("FAIL frz_wait_state[%0d] got=%0d want=1", i, state); end
      total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL frz_wait_stall[%0d] got=%0b want=0", i, stall_if_id); end
      total++; if (fwd_sel1 !== 2'b01) begin bad++; $display("FAIL frz_wait_sel1[%0d] got=%0d want=1", i, fwd_sel1); end
    end
    tick();
    mem_busy  = 1'b0;
    br_select = 1'b0;
    clear_id();
    settle();
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL frz_exit_freeze got=%0b want=0", freeze); end
    total++; if (state !== 2'b01) begin bad++; $display("FAIL frz_exit_state got=%0d want=1", state); end
    total++; if (fwd_sel1 !== 2'b01) begin bad++; $display("FAIL frz_exit_sel1 got=%0d want=1", fwd_sel1); end
    tick();
    set_id(1'b1, 5'd4, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);
    settle();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL frz_run_state got=%0d want=0", state); end
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL frz_run_stall got=%0b want=0", stall_if_id); end
    total++; if (fwd_sel1 !== 2'b00) begin bad++; $display("FAIL frz_run_sel1 got=%0d want=0", fwd_sel1); end
    tick();
    clear_id();
    settle();
    total++; if (fwd_sel1 !== 2'b10) begin bad++; $display("FAIL frz_shift_sel1 got=%0d want=2", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'b00) begin bad++; $display("FAIL frz_shift_sel2 got=%0d want=0", fwd_sel2); end
  endtask

  task automatic test_no_fwd();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    settle();
    total++; if (nf_stall !== 1'b0) begin bad++; $display("FAIL nf_a_stall got=%0b want=0", nf_stall); end
    tick();
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
    settle();
    total++; if (nf_stall !== 1'b1) begin bad++; $display("FAIL nf_exe_stall got=%0b want=1", nf_stall); end
    total++; if (nf_bubble !== 1'b1) begin bad++; $display("FAIL nf_exe_bubble got=%0b want=1", nf_bubble); end
    tick();
    settle();
    total++; if (nf_stall !== 1'b1) begin bad++; $display("FAIL nf_mem_stall got=%0b want=1", nf_stall); end
    total++; if (nf_fwd_sel1 !== 2'b00) begin bad++; $display("FAIL nf_mem_sel1 got=%0d want=0", nf_fwd_sel1); end
    tick();
    settle();
    total++; if (nf_stall !== 1'b0) begin bad++; $display("FAIL nf_done_stall got=%0b want=0", nf_stall); end
    total++; if (nf_bubble !== 1'b0) begin bad++; $display("FAIL nf_done_bubble got=%0b want=0", nf_bubble); end
    tick();
    clear_id();
    settle();
    total++; if (nf_fwd_sel1 !== 2'b00) begin bad++; $display("FAIL nf_e_sel1 got=%0d want=0", nf_fwd_sel1); end
    total++; if (nf_fwd_sel2 !== 2'b00) begin bad++; $display("FAIL nf_e_sel2 got=%0d want=0", nf_fwd_sel2); end
  endtask

  task automatic test_r0();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL r0_lu_stall got=%0b want=0", stall_if_id); end
    total++; if (bubble_id_exe !== 1'b0) begin bad++; $display("FAIL r0_lu_bubble got=%0b want=0", bubble_id_exe); end
    total++; if (nf_stall !== 1'b0) begin bad++; $display("FAIL r0_nf_exe_stall got=%0b want=0", nf_stall); end
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    total++; if (fwd_sel1 !== 2'b00) begin bad++; $display("FAIL r0_sel1 got=%0d want=0", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'b00) begin bad++; $display("FAIL r0_sel2 got=%0d want=0", fwd_sel2); end
    total++; if (nf_stall !== 1'b0) begin bad++; $display("FAIL r0_nf_mem_stall got=%0b want=0", nf_stall); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_busy = 1'b1;
    settle();
    total++; if (to_freeze !== 1'b1) begin bad++; $display("FAIL to_run_freeze got=%0b want=1", to_freeze); end
    total++; if (to_state !== 2'b00) begin bad++; $display("FAIL to_run_state got=%0d want=0", to_state); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      settle();
      total++; if (to_state !== 2'b01) begin bad++; $display("FAIL to_wait_state[%0d] got=%0d want=1", i, to_state); end
      total++; if (to_mem_err !== 1'b0) begin bad++; $display("FAIL to_wait_err[%0d] got=%0b want=0", i, to_mem_err); end
    end
    tick();
    settle();
    total++; if (to_state !== 2'b10) begin bad++; $display("FAIL to_err_state got=%0d want=2", to_state); end
    total++; if (to_mem_err !== 1'b1) begin bad++; $display("FAIL to_err_flag got=%0b want=1", to_mem_err); end
    total++; if (to_freeze !== 1'b1) begin bad++; $display("FAIL to_err_freeze got=%0b want=1", to_freeze); end
    total++; if (state !== 2'b01) begin bad++; $display("FAIL to_long_state got=%0d want=1", state); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL to_long_err got=%0b want=0", mem_err); end
    mem_busy = 1'b0;
    tick();
    settle();
    total++; if (to_state !== 2'b10) begin bad++; $display("FAIL to_sticky_state got=%0d want=2", to_state); end
    total++; if (to_freeze !== 1'b1) begin bad++; $display("FAIL to_sticky_freeze got=%0b want=1", to_freeze); end
    rst = 1'b0;
    #1;
    total++; if (to_state !== 2'b00) begin bad++; $display("FAIL to_arst_state got=%0d want=0", to_state); end
    total++; if (to_mem_err !== 1'b0) begin bad++; $display("FAIL to_arst_err got=%0b want=0", to_mem_err); end
    total++; if (to_freeze !== 1'b0) begin bad++; $display("FAIL to_arst_freeze got=%0b want=0", to_freeze); end
    total++; if (to_fwd_sel1 !== 2'b00) begin bad++; $display("FAIL to_arst_sel1 got=%0d want=0", to_fwd_sel1); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL to_arst_main_state got=%0d want=0", state); end
    do_reset();
  endtask

  initial begin
    rst = 1'b0;
    clear_id();
    br_select = 1'b0;
    mem_busy  = 1'b0;
    test_reset();
    test_forward();
    test_priority();
    test_load_use();
    test_branch();
    test_freeze();
    test_no_fwd();
    test_r0();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
